control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle Moore control sequencer for the accumulator-less datapath.
// Ports: Clock_i, Reset_i (sync high), Stop_i, IR_i, Mem_ready_i -> Ctl_o[27:0],
//   Reg_enableIn_o, Run_o, Retired_o, Trap_o. Optional macro CTRL_SEQ_TRAP_EN traps unmapped opcodes.
module control_sequencer #(
  parameter int IR_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter int LINK_REG = 14,
  parameter int CNT_W    = 16
) (
  input  logic                Clock_i,
  input  logic                Reset_i,
  input  logic                Stop_i,
  input  logic [IR_WIDTH-1:0] IR_i,
  input  logic                Mem_ready_i,
  output logic [27:0]         Ctl_o,
  output logic [NUM_REGS-1:0] Reg_enableIn_o,
  output logic                Run_o,
  output logic [CNT_W-1:0]    Retired_o,
  output logic                Trap_o
);

  localparam int PCOUT = 0;
  localparam int ZHO   = 1;
  localparam int ZLO   = 2;
  localparam int MDRO  = 3;
  localparam int MARE  = 4;
  localparam int PCE   = 5;
  localparam int MDRE  = 6;
  localparam int IRE   = 7;
  localparam int YE    = 8;
  localparam int INCPC = 9;
  localparam int MDRR  = 10;
  localparam int HIIN  = 11;
  localparam int LOIN  = 12;
  localparam int HIO   = 13;
  localparam int LOO   = 14;
  localparam int ZHI   = 15;
  localparam int ZLI   = 16;
  localparam int COUT  = 17;
  localparam int RAMW  = 18;
  localparam int GRA   = 19;
  localparam int GRB   = 20;
  localparam int GRC   = 21;
  localparam int RE    = 22;
  localparam int ROUT  = 23;
  localparam int BAO   = 24;
  localparam int CONE  = 25;
  localparam int OUTE  = 26;
  localparam int INPO  = 27;

  typedef enum logic [4:0] {
    C_RST, C_F0, C_F1, C_F2,
    C_ALU, C_IMM, C_MD, C_UN,
    C_LD, C_LDI, C_ST, C_BR,
    C_JR, C_JAL, C_MFHI, C_MFLO,
    C_IN, C_OUT, C_NOP, C_HALT,
    C_TRAP
  } cls_e;

  cls_e             cls_q, cls_d, dec_cls;
  logic [2:0]       step_q, step_d, last_step;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             retire, mem_wait;
  logic [4:0]       opcode;
  logic             unused_ir;

  assign opcode    = IR_i[IR_WIDTH-1 -: 5];
  assign unused_ir = ^IR_i[IR_WIDTH-6:0];

  always_comb begin
    dec_cls = C_NOP;
    case (opcode)
      5'b00000: dec_cls = C_LD;
      5'b00001: dec_cls = C_LDI;
      5'b00010: dec_cls = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010:
        dec_cls = C_ALU;
      5'b01011, 5'b01100, 5'b01101: dec_cls = C_IMM;
      5'b01110, 5'b01111: dec_cls = C_MD;
      5'b10000, 5'b10001: dec_cls = C_UN;
      5'b10010: dec_cls = C_BR;
      5'b10011: dec_cls = C_JR;
      5'b10100: dec_cls = C_JAL;
      5'b10101: dec_cls = C_IN;
      5'b10110: dec_cls = C_OUT;
      5'b10111: dec_cls = C_MFHI;
      5'b11000: dec_cls = C_MFLO;
      5'b11001: dec_cls = C_NOP;
      5'b11010: dec_cls = C_HALT;
`ifdef CTRL_SEQ_TRAP_EN
      default:  dec_cls = C_TRAP;
`else
      default:  dec_cls = C_NOP;
`endif
    endcase
  end

  always_comb begin
    last_step = 3'd1;
    case (cls_q)
      C_ALU, C_IMM, C_LDI: last_step = 3'd3;
      C_MD:                last_step = 3'd4;
      C_UN, C_JAL:         last_step = 3'd2;
      C_LD, C_ST, C_BR:    last_step = 3'd5;
      default:             last_step = 3'd1;
    endcase
  end

  // Memory-access steps hold until the memory handshake completes.
  assign mem_wait = (cls_q == C_LD && step_q == 3'd4) ||
                    (cls_q == C_ST && step_q == 3'd5);

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      cls_q  <= C_RST;
      step_q <= 3'd1;
      ret_q  <= '0;
    end else begin
      cls_q  <= cls_d;
      step_q <= step_d;
      ret_q  <= ret_d;
    end
  end

  always_comb begin
    cls_d  = cls_q;
    step_d = step_q;
    retire = 1'b0;
    case (cls_q)
      C_RST: begin
        cls_d  = C_F0;
        step_d = 3'd1;
      end
      C_F0: cls_d = C_F1;
      C_F1: if (Mem_ready_i) cls_d = C_F2;
      C_F2: begin
        cls_d  = dec_cls;
        step_d = 3'd1;
      end
      C_HALT, C_TRAP: begin
        cls_d = cls_q;
      end
      default: begin
        if (!mem_wait || Mem_ready_i) begin
          if (step_q == last_step) begin
            cls_d  = C_F0;
            step_d = 3'd1;
            retire = 1'b1;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
    endcase
    // A trap stays a trap; anything else is aborted into HALT.
    if (Stop_i && cls_q != C_TRAP) begin
      cls_d  = C_HALT;
      step_d = 3'd1;
      retire = 1'b0;
    end
  end

  assign ret_d     = retire ? ret_q + CNT_W'(1) : ret_q;
  assign Retired_o = ret_q;

  always_comb begin
    Ctl_o          = '0;
    Reg_enableIn_o = '0;
    Run_o          = 1'b1;
    Trap_o         = 1'b0;
    case (cls_q)
      C_F0: begin
        Ctl_o[PCOUT] = 1'b1;
        Ctl_o[MARE]  = 1'b1;
        Ctl_o[INCPC] = 1'b1;
      end
      C_F1: begin
        Ctl_o[MDRE] = 1'b1;
        Ctl_o[MDRR] = 1'b1;
        Ctl_o[ZLO]  = 1'b1;
        // The incremented PC is latched only once, on the completing cycle.
        Ctl_o[PCE]  = Mem_ready_i;
      end
      C_F2: begin
        Ctl_o[MDRO] = 1'b1;
        Ctl_o[IRE]  = 1'b1;
      end
      C_ALU, C_IMM: begin
        case (step_q)
          3'd1: begin
            Ctl_o[GRB]  = 1'b1;
            Ctl_o[ROUT] = 1'b1;
            Ctl_o[YE]   = 1'b1;
          end
          3'd2: begin
            Ctl_o[ZLI] = 1'b1;
            if (cls_q == C_ALU) begin
              Ctl_o[GRC]  = 1'b1;
              Ctl_o[ROUT] = 1'b1;
            end else begin
              Ctl_o[COUT] = 1'b1;
            end
          end
          default: begin
            Ctl_o[ZLO] = 1'b1;
            Ctl_o[GRA] = 1'b1;
            Ctl_o[RE]  = 1'b1;
          end
        endcase
      end
      C_MD: begin
        case (step_q)
          3'd1: begin
            Ctl_o[GRA]  = 1'b1;
            Ctl_o[ROUT] = 1'b1;
            Ctl_o[YE]   = 1'b1;
          end
          3'd2: begin
            Ctl_o[GRB]  = 1'b1;
            Ctl_o[ROUT] = 1'b1;
            Ctl_o[ZLI]  = 1'b1;
            Ctl_o[ZHI]  = 1'b1;
          end
          3'd3: begin
            Ctl_o[ZLO]  = 1'b1;
            Ctl_o[LOIN] = 1'b1;
          end
          default: begin
            Ctl_o[ZHO]  = 1'b1;
            Ctl_o[HIIN] = 1'b1;
          end
        endcase
      end
      C_UN: begin
        if (step_q == 3'd1) begin
          Ctl_o[GRB]  = 1'b1;
          Ctl_o[ROUT] = 1'b1;
          Ctl_o[ZLI]  = 1'b1;
        end else begin
          Ctl_o[ZLO] = 1'b1;
          Ctl_o[GRA] = 1'b1;
          Ctl_o[RE]  = 1'b1;
        end
      end
      C_LD, C_LDI, C_ST: begin
        case (step_q)
          3'd1: begin
            Ctl_o[GRB] = 1'b1;
            Ctl_o[BAO] = 1'b1;
            Ctl_o[YE]  = 1'b1;
          end
          3'd2: begin
            Ctl_o[COUT] = 1'b1;
            Ctl_o[ZLI]  = 1'b1;
          end
          3'd3: begin
            Ctl_o[ZLO] = 1'b1;
            if (cls_q == C_LDI) begin
              Ctl_o[GRA] = 1'b1;
              Ctl_o[RE]  = 1'b1;
            end else begin
              Ctl_o[MARE] = 1'b1;
            end
          end
          3'd4: begin
            Ctl_o[MDRE] = 1'b1;
            if (cls_q == C_LD) begin
              Ctl_o[MDRR] = 1'b1;
            end else begin
              Ctl_o[GRA]  = 1'b1;
              Ctl_o[ROUT] = 1'b1;
            end
          end
          default: begin
            Ctl_o[MDRO] = 1'b1;
            if (cls_q == C_LD) begin
              Ctl_o[GRA] = 1'b1;
              Ctl_o[RE]  = 1'b1;
            end else begin
              Ctl_o[RAMW] = 1'b1;
            end
          end
        endcase
      end
      C_BR: begin
        case (step_q)
          3'd1: begin
            Ctl_o[GRA]  = 1'b1;
            Ctl_o[ROUT] = 1'b1;
            Ctl_o[CONE] = 1'b1;
          end
          // Bubble while the condition flop settles.
          3'd2: Ctl_o = '0;
          3'd3: begin
            Ctl_o[PCOUT] = 1'b1;
            Ctl_o[YE]    = 1'b1;
          end
          3'd4: begin
            Ctl_o[COUT] = 1'b1;
            Ctl_o[ZLI]  = 1'b1;
          end
          default: begin
            Ctl_o[ZLO] = 1'b1;
            Ctl_o[PCE] = 1'b1;
          end
        endcase
      end
      C_JAL, C_JR: begin
        if (cls_q == C_JAL && step_q == 3'd1) begin
          Ctl_o[PCOUT]             = 1'b1;
          Reg_enableIn_o[LINK_REG] = 1'b1;
        end else begin
          Ctl_o[GRA]  = 1'b1;
          Ctl_o[ROUT] = 1'b1;
          Ctl_o[PCE]  = 1'b1;
        end
      end
      C_MFHI: begin
        Ctl_o[HIO] = 1'b1;
        Ctl_o[GRA] = 1'b1;
        Ctl_o[RE]  = 1'b1;
      end
      C_MFLO: begin
        Ctl_o[LOO] = 1'b1;
        Ctl_o[GRA] = 1'b1;
        Ctl_o[RE]  = 1'b1;
      end
      C_IN: begin
        Ctl_o[INPO] = 1'b1;
        Ctl_o[GRA]  = 1'b1;
        Ctl_o[RE]   = 1'b1;
      end
      C_OUT: begin
        Ctl_o[GRA]  = 1'b1;
        Ctl_o[ROUT] = 1'b1;
        Ctl_o[OUTE] = 1'b1;
      end
      C_HALT: Run_o = 1'b0;
      C_TRAP: begin
        Run_o = 1'b0;
`ifdef CTRL_SEQ_TRAP_EN
        Trap_o = 1'b1;
`endif
      end
      default: Ctl_o = '0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random stimulus against an instruction-level step-table model;
// expected per-cycle outputs are queued and checked by an independent monitor.
module tb_control_sequencer;

  localparam int CNT_W = 4;

  localparam int PCOUT = 0,  ZHO = 1,   ZLO = 2,   MDRO = 3;
  localparam int MARE = 4,   PCE = 5,   MDRE = 6,  IRE = 7;
  localparam int YE = 8,     INCPC = 9, MDRR = 10, HIIN = 11;
  localparam int LOIN = 12,  HIO = 13,  LOO = 14,  ZHI = 15;
  localparam int ZLI = 16,   COUT = 17, RAMW = 18, GRA = 19;
  localparam int GRB = 20,   GRC = 21,  RE = 22,   ROUT = 23;
  localparam int BAO = 24,   CONE = 25, OUTE = 26, INPO = 27;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stop = 1'b0;
  logic [31:0]       ir = '0;
  logic              mr = 1'b1;
  logic [27:0]       ctl;
  logic [15:0]       regen;
  logic              run, trap;
  logic [CNT_W-1:0]  retired;

  control_sequencer #(
    .IR_WIDTH(32), .NUM_REGS(16), .LINK_REG(14), .CNT_W(CNT_W)
  ) dut (
    .Clock_i(clk), .Reset_i(rst), .Stop_i(stop), .IR_i(ir),
    .Mem_ready_i(mr), .Ctl_o(ctl), .Reg_enableIn_o(regen),
    .Run_o(run), .Retired_o(retired), .Trap_o(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] ctl;
    logic [15:0] reg_en;
    bit wait_mem, last, f1, dec, run, trap, sticky;
  } step_t;

  typedef struct {
    logic [27:0] ctl;
    logic [15:0] reg_en;
    logic run, trap;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t  expq[$];
  step_t plan[$];
  step_t cur;
  int    checks = 0;
  int    failures = 0;
  int    ret_m = 0;
  bit    known = 0;

  function automatic logic [27:0] m(input int a, input int b = -1,
                                    input int c = -1, input int d = -1);
    logic [27:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    if (d >= 0) r[d] = 1'b1;
    return r;
  endfunction

  function automatic step_t st(input logic [27:0] c, input bit last = 0,
                               input bit w = 0);
    step_t s;
    s.ctl = c; s.reg_en = '0; s.wait_mem = w; s.last = last;
    s.f1 = 0; s.dec = 0; s.run = 1; s.trap = 0; s.sticky = 0;
    return s;
  endfunction

  function automatic step_t stop_step(input bit is_trap);
    step_t s;
    s = st('0);
    s.run = 0; s.sticky = 1; s.trap = is_trap;
    return s;
  endfunction

  task automatic push_fetch();
    step_t s;
    plan.push_back(st(m(PCOUT, MARE, INCPC)));
    s = st(m(MDRE, MDRR, ZLO)); s.f1 = 1; s.wait_mem = 1;
    plan.push_back(s);
    s = st(m(MDRO, IRE)); s.dec = 1;
    plan.push_back(s);
  endtask

  task automatic expand(input logic [4:0] op);
    step_t s;
    case (op)
      5'd0: begin
        plan.push_back(st(m(GRB, BAO, YE)));
        plan.push_back(st(m(COUT, ZLI)));
        plan.push_back(st(m(ZLO, MARE)));
        plan.push_back(st(m(MDRR, MDRE), 0, 1));
        plan.push_back(st(m(MDRO, GRA, RE), 1));
      end
      5'd1: begin
        plan.push_back(st(m(GRB, BAO, YE)));
        plan.push_back(st(m(COUT, ZLI)));
        plan.push_back(st(m(ZLO, GRA, RE), 1));
      end
      5'd2: begin
        plan.push_back(st(m(GRB, BAO, YE)));
        plan.push_back(st(m(COUT, ZLI)));
        plan.push_back(st(m(ZLO, MARE)));
        plan.push_back(st(m(GRA, ROUT, MDRE)));
        plan.push_back(st(m(MDRO, RAMW), 1, 1));
      end
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
        plan.push_back(st(m(GRB, ROUT, YE)));
        plan.push_back(st(m(GRC, ROUT, ZLI)));
        plan.push_back(st(m(ZLO, GRA, RE), 1));
      end
      5'd11, 5'd12, 5'd13: begin
        plan.push_back(st(m(GRB, ROUT, YE)));
        plan.push_back(st(m(COUT, ZLI)));
        plan.push_back(st(m(ZLO, GRA, RE), 1));
      end
      5'd14, 5'd15: begin
        plan.push_back(st(m(GRA, ROUT, YE)));
        plan.push_back(st(m(GRB, ROUT, ZLI, ZHI)));
        plan.push_back(st(m(ZLO, LOIN)));
        plan.push_back(st(m(ZHO, HIIN), 1));
      end
      5'd16, 5'd17: begin
        plan.push_back(st(m(GRB, ROUT, ZLI)));
        plan.push_back(st(m(ZLO, GRA, RE), 1));
      end
      5'd18: begin
        plan.push_back(st(m(GRA, ROUT, CONE)));
        plan.push_back(st('0));
        plan.push_back(st(m(PCOUT, YE)));
        plan.push_back(st(m(COUT, ZLI)));
        plan.push_back(st(m(ZLO, PCE), 1));
      end
      5'd19: plan.push_back(st(m(GRA, ROUT, PCE), 1));
      5'd20: begin
        s = st(m(PCOUT)); s.reg_en = 16'h4000;
        plan.push_back(s);
        plan.push_back(st(m(GRA, ROUT, PCE), 1));
      end
      5'd21: plan.push_back(st(m(INPO, GRA, RE), 1));
      5'd22: plan.push_back(st(m(GRA, ROUT, OUTE), 1));
      5'd23: plan.push_back(st(m(HIO, GRA, RE), 1));
      5'd24: plan.push_back(st(m(LOO, GRA, RE), 1));
      5'd25: plan.push_back(st('0, 1));
      5'd26: plan.push_back(stop_step(0));
      default: begin
`ifdef CTRL_SEQ_TRAP_EN
        plan.push_back(stop_step(1));
`else
        plan.push_back(st('0, 1));
`endif
      end
    endcase
  endtask

  task automatic model_edge();
    if (rst) begin
      cur = st('0);
      plan.delete();
      ret_m = 0;
      known = 1;
    end else if (!known || cur.sticky) begin
      cur = cur;
    end else if (stop) begin
      cur = stop_step(0);
      plan.delete();
    end else if (cur.wait_mem && !mr) begin
      cur = cur;
    end else begin
      if (cur.last) ret_m = (ret_m + 1) % (1 << CNT_W);
      if (cur.dec) expand(ir[31:27]);
      if (plan.size() == 0) push_fetch();
      cur = plan.pop_front();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("ctl", 32'(ctl), 32'(e.ctl));
        chk("reg_en", 32'(regen), 32'(e.reg_en));
        chk("run", 32'(run), 32'(e.run));
        chk("trap", 32'(trap), 32'(e.trap));
        chk("retired", 32'(retired), 32'(e.ret));
      end
    end
  end

  initial begin : stim
    exp_t e;
    int   halted;
    halted = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (cyc < 2) begin
        rst = 1; stop = 0; mr = 1; ir = 32'h1800_0000;
      end else begin
        rst  = (halted > 3) || ($urandom_range(0, 299) == 0);
        stop = ($urandom_range(0, 99) == 0);
        mr   = ($urandom_range(0, 9) < 7);
        ir   = $urandom;
        if ($urandom_range(0, 3) == 0) ir[31:27] = 5'd25;
        if ($urandom_range(0, 7) == 0) ir[31:27] = 5'd0;
      end
      if (known) begin
        e.ctl    = cur.ctl | ((cur.f1 && mr) ? m(PCE) : 28'h0);
        e.reg_en = cur.reg_en;
        e.run    = cur.run;
        e.trap   = cur.trap;
        e.ret    = CNT_W'(ret_m);
        expq.push_back(e);
      end
      halted = (known && cur.sticky) ? halted + 1 : 0;
      model_edge();
    end
    @(negedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
